// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared encodings and widths for the instruction/data memory arbiter.
package cpu_mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

endpackage

// File: rtl/cpu_mem_arbiter.sv
// Merges the core's fetch and data channels onto one memory port, one
// outstanding transaction at a time, with fetch and stall event counters.
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PC,
  input  logic              Inst_Req_Valid,
  output logic              Inst_Req_Ready,
  output logic [DATA_W-1:0] Instruction,
  output logic              Inst_Valid,
  input  logic              Inst_Ready,
  input  logic [ADDR_W-1:0] Address,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [DATA_W-1:0] Write_data,
  input  logic [STRB_W-1:0] Write_strb,
  output logic              Mem_Req_Ready,
  output logic [DATA_W-1:0] Read_data,
  output logic              Read_data_Valid,
  input  logic              Read_data_Ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  output logic [CNT_W-1:0]  arb_fetch_cnt,
  output logic [CNT_W-1:0]  arb_wait_cnt
);

  state_e            state_q;
  owner_e            owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [CNT_W-1:0]  fetch_cnt_q;
  logic [CNT_W-1:0]  wait_cnt_q;

  logic grant_data;
  logic grant_inst;
  logic rsp_fire;

  // Data wins over fetch; grants only happen from IDLE.
  assign grant_data = (state_q == IDLE) && (MemRead || MemWrite);
  assign grant_inst = (state_q == IDLE) && !(MemRead || MemWrite) && Inst_Req_Valid;
  assign rsp_fire   = mem_rvalid && mem_rready;

  // Transaction FSM with request/owner registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OWN_INST;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_data) begin
            state_q <= REQ;
            owner_q <= OWN_DATA;
            addr_q  <= Address;
            wen_q   <= MemWrite;
            wdata_q <= MemWrite ? Write_data : '0;
            wstrb_q <= MemWrite ? Write_strb : '0;
          end else if (grant_inst) begin
            state_q <= REQ;
            owner_q <= OWN_INST;
            addr_q  <= PC;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            state_q <= wen_q ? IDLE : RSP;
          end
        end
        RSP: begin
          if (rsp_fire) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
    end else if (grant_inst) begin
      fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
    end else if ((state_q == REQ) && !mem_req_ready) begin
      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end
  end

  // Response steering: only the owner sees valid and drives mem_rready.
  always_comb begin
    Inst_Valid      = 1'b0;
    Read_data_Valid = 1'b0;
    mem_rready      = 1'b0;
    if (state_q == RSP) begin
      if (owner_q == OWN_INST) begin
        Inst_Valid = mem_rvalid;
        mem_rready = Inst_Ready;
      end else begin
        Read_data_Valid = mem_rvalid;
        mem_rready      = Read_data_Ready;
      end
    end
  end

  assign Inst_Req_Ready = grant_inst;
  assign Mem_Req_Ready  = grant_data;
  assign Instruction    = mem_rdata;
  assign Read_data      = mem_rdata;
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wstrb      = wstrb_q;
  assign mem_req_valid  = (state_q == REQ);
  assign arb_fetch_cnt  = fetch_cnt_q;
  assign arb_wait_cnt   = wait_cnt_q;

endmodule
